// File: rtl/pcs_pkg.sv
// Shared constants, state and block-class types for the 64b/66b transmit encoder.
package pcs_pkg;

   localparam logic [1:0] SyncData = 2'b01;
   localparam logic [1:0] SyncCtrl = 2'b10;

   localparam logic [7:0] BlockTypeC = 8'h1E;
   localparam logic [7:0] BlockTypeS = 8'h78;

   localparam logic [7:0] MiiIdle  = 8'h07;
   localparam logic [7:0] MiiStart = 8'hFB;
   localparam logic [7:0] MiiTerm  = 8'hFD;
   localparam logic [7:0] MiiError = 8'hFE;

   localparam logic [6:0] CodeIdle  = 7'h00;
   localparam logic [6:0] CodeError = 7'h1E;

   localparam logic [63:0] IdlePayload  = {56'h0, BlockTypeC};
   localparam logic [63:0] ErrorPayload = {{8{CodeError}}, BlockTypeC};

   typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;

   typedef enum logic [2:0] {ClassD, ClassC, ClassS, ClassT, ClassE} blk_class_e;

   // Block type for a terminate whose /T/ sits in the given lane.
   function automatic logic [7:0] t_block_type(input logic [2:0] lane);
      logic [7:0] bt;
      case (lane)
         3'd0:    bt = 8'h87;
         3'd1:    bt = 8'h99;
         3'd2:    bt = 8'hAA;
         3'd3:    bt = 8'hB4;
         3'd4:    bt = 8'hCC;
         3'd5:    bt = 8'hD2;
         3'd6:    bt = 8'hE1;
         default: bt = 8'hFF;
      endcase
      return bt;
   endfunction

   // Control mask for a terminate in the given lane: that lane and all above are control.
   function automatic logic [7:0] t_ctrl_mask(input logic [2:0] lane);
      return 8'hFF << lane;
   endfunction

endpackage

// File: rtl/pcs_block_classifier.sv
// Combinational classification of one MII word into D/C/S/T/E with its 64-bit payload.
module pcs_block_classifier
   import pcs_pkg::*;
(
   input  logic [63:0] tx_data_i,
   input  logic [7:0]  tx_ctrl_i,
   output blk_class_e  blk_class_o,
   output logic [2:0]  t_lane_o,
   output logic [63:0] payload_o
);

   logic [7:0]  lane [8];
   logic        c_ok;
   logic        t_ok;
   logic        t_hit;
   logic [2:0]  t_idx;
   logic [63:0] c_payload;
   logic [63:0] t_payload;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         lane[k] = tx_data_i[8*k +: 8];
      end
   end

   always_comb begin
      c_ok      = 1'b1;
      c_payload = {56'h0, BlockTypeC};
      for (int k = 0; k < 8; k++) begin
         if (lane[k] == MiiIdle) begin
            c_payload[8+7*k +: 7] = CodeIdle;
         end else if (lane[k] == MiiError) begin
            c_payload[8+7*k +: 7] = CodeError;
         end else begin
            c_ok = 1'b0;
         end
      end
   end

   always_comb begin
      t_ok  = 1'b0;
      t_hit = 1'b0;
      t_idx = '0;
      for (int k = 0; k < 8; k++) begin
         t_ok = (tx_ctrl_i == t_ctrl_mask(3'(k))) && (lane[k] == MiiTerm);
         for (int j = k + 1; j < 8; j++) begin
            if (lane[j] != MiiIdle) t_ok = 1'b0;
         end
         if (t_ok) begin
            t_hit = 1'b1;
            t_idx = 3'(k);
         end
      end
      // Data lanes preceding /T/ pack directly after the type byte.
      t_payload = {56'h0, t_block_type(t_idx)};
      for (int j = 0; j < 7; j++) begin
         if (3'(j) < t_idx) t_payload[8+8*j +: 8] = lane[j];
      end
   end

   always_comb begin
      blk_class_o = ClassE;
      payload_o   = ErrorPayload;
      if (tx_ctrl_i == 8'h00) begin
         blk_class_o = ClassD;
         payload_o   = tx_data_i;
      end else if (tx_ctrl_i == 8'hFF && c_ok) begin
         blk_class_o = ClassC;
         payload_o   = c_payload;
      end else if (tx_ctrl_i == 8'h01 && lane[0] == MiiStart) begin
         blk_class_o = ClassS;
         payload_o   = {tx_data_i[63:8], BlockTypeS};
      end else if (t_hit) begin
         blk_class_o = ClassT;
         payload_o   = t_payload;
      end
   end

   assign t_lane_o = t_idx;

endmodule

// File: rtl/pcs_64b66b_encoder.sv
// 64b/66b transmit encoder: classifies MII words, sequences them through the transmit
// state machine, and registers the 66-bit block plus frame/error counters.
module pcs_64b66b_encoder
   import pcs_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CTRL_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
   input  logic                  i_valid,
   output logic [65:0]           o_tx_coded,
   output logic                  o_valid,
   output logic [15:0]           o_frame_count,
   output logic [15:0]           o_err_count
);

   tx_state_e   state_q, state_d;
   blk_class_e  blk_class;
   logic [2:0]  t_lane;
   logic [63:0] payload;

   logic [65:0] coded_d, coded_q;
   logic        valid_d, valid_q;
   logic [15:0] frame_d, frame_q;
   logic [15:0] err_d, err_q;

   logic unused_t_lane;
   assign unused_t_lane = ^t_lane;

   pcs_block_classifier u_classifier (
      .tx_data_i   (i_tx_data),
      .tx_ctrl_i   (i_tx_ctrl),
      .blk_class_o (blk_class),
      .t_lane_o    (t_lane),
      .payload_o   (payload)
   );

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= TX_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_valid) begin
         unique case (state_q)
            TX_INIT, TX_C, TX_T: begin
               case (blk_class)
                  ClassC:  state_d = TX_C;
                  ClassS:  state_d = TX_D;
                  default: state_d = TX_E;
               endcase
            end
            TX_D: begin
               case (blk_class)
                  ClassD:  state_d = TX_D;
                  ClassT:  state_d = TX_T;
                  default: state_d = TX_E;
               endcase
            end
            TX_E: begin
               case (blk_class)
                  ClassC:  state_d = TX_C;
                  ClassD:  state_d = TX_D;
                  ClassT:  state_d = TX_T;
                  default: state_d = TX_E;
               endcase
            end
            default: state_d = TX_INIT;
         endcase
      end
   end

   // Landing in (or staying in) TX_E replaces the word's own encoding with an error block.
   always_comb begin
      coded_d = coded_q;
      valid_d = 1'b0;
      frame_d = frame_q;
      err_d   = err_q;
      if (i_valid) begin
         valid_d = 1'b1;
         if (state_d == TX_E) begin
            coded_d = {ErrorPayload, SyncCtrl};
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
         end else begin
            coded_d = {payload, (blk_class == ClassD) ? SyncData : SyncCtrl};
            if (blk_class == ClassS) frame_d = frame_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         coded_q <= {IdlePayload, SyncCtrl};
         valid_q <= 1'b0;
         frame_q <= 16'h0;
         err_q   <= 16'h0;
      end else begin
         coded_q <= coded_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
         err_q   <= err_d;
      end
   end

   assign o_tx_coded    = coded_q;
   assign o_valid       = valid_q;
   assign o_frame_count = frame_q;
   assign o_err_count   = err_q;

endmodule

// File: tb/tb_pcs_64b66b_encoder.sv
// Directed-vector bench for the 64b/66b encoder with hand-computed expected blocks.
module tb_pcs_64b66b_encoder;
   import pcs_pkg::*;

   localparam logic [65:0] IdleBlk = {56'h0, 8'h1E, 2'b10};
   localparam logic [65:0] ErrBlk  = {{8{7'h1E}}, 8'h1E, 2'b10};

   logic        clk = 1'b0;
   logic        i_rst;
   logic [63:0] i_tx_data;
   logic [7:0]  i_tx_ctrl;
   logic        i_valid;
   logic [65:0] o_tx_coded;
   logic        o_valid;
   logic [15:0] o_frame_count;
   logic [15:0] o_err_count;

   int vectors = 0;
   int fails   = 0;

   pcs_64b66b_encoder #(
      .DATA_WIDTH (64),
      .CTRL_WIDTH (8)
   ) dut (
      .clk           (clk),
      .i_rst         (i_rst),
      .i_tx_data     (i_tx_data),
      .i_tx_ctrl     (i_tx_ctrl),
      .i_valid       (i_valid),
      .o_tx_coded    (o_tx_coded),
      .o_valid       (o_valid),
      .o_frame_count (o_frame_count),
      .o_err_count   (o_err_count)
   );

   always #5 clk = ~clk;

   // Present one word for one edge; returns 1 time unit after that edge.
   task automatic apply(input logic [7:0] c, input logic [63:0] d, input logic v);
      i_tx_ctrl = c;
      i_tx_data = d;
      i_valid   = v;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic test_reset;
      i_rst     = 1'b1;
      i_valid   = 1'b0;
      i_tx_ctrl = 8'h00;
      i_tx_data = 64'h0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (o_valid !== 1'b0) begin
         fails++; $display("FAIL reset_valid: got %b want 0", o_valid);
      end
      vectors++;
      if (o_tx_coded !== IdleBlk) begin
         fails++; $display("FAIL reset_coded: got %h want %h", o_tx_coded, IdleBlk);
      end
      vectors++;
      if (o_frame_count !== 16'h0) begin
         fails++; $display("FAIL reset_frame: got %h want 0000", o_frame_count);
      end
      vectors++;
      if (o_err_count !== 16'h0) begin
         fails++; $display("FAIL reset_err: got %h want 0000", o_err_count);
      end
      vectors++;
      if (dut.state_q !== TX_INIT) begin
         fails++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, TX_INIT);
      end
      i_rst = 1'b0;
   endtask

   task automatic test_idle;
      apply(8'hFF, 64'h0707070707070707, 1'b1);
      vectors++;
      if (o_tx_coded !== IdleBlk) begin
         fails++; $display("FAIL idle_coded: got %h want %h", o_tx_coded, IdleBlk);
      end
      vectors++;
      if (o_valid !== 1'b1) begin
         fails++; $display("FAIL idle_valid: got %b want 1", o_valid);
      end
      vectors++;
      if (dut.state_q !== TX_C) begin
         fails++; $display("FAIL idle_state: got %0d want %0d", dut.state_q, TX_C);
      end
   endtask

   task automatic test_start;
      apply(8'h01, 64'hD5555555555555FB, 1'b1);
      vectors++;
      if (o_tx_coded !== {56'hD5555555555555, 8'h78, 2'b10}) begin
         fails++; $display("FAIL start_coded: got %h want %h", o_tx_coded,
                           {56'hD5555555555555, 8'h78, 2'b10});
      end
      vectors++;
      if (o_frame_count !== 16'd1) begin
         fails++; $display("FAIL start_frame: got %h want 0001", o_frame_count);
      end
   endtask

   task automatic test_data_term;
      apply(8'h00, 64'h1122334455667788, 1'b1);
      vectors++;
      if (o_tx_coded !== {64'h1122334455667788, 2'b01}) begin
         fails++; $display("FAIL data_coded: got %h want %h", o_tx_coded,
                           {64'h1122334455667788, 2'b01});
      end
      apply(8'hF8, 64'h07070707FD332211, 1'b1);
      vectors++;
      if (o_tx_coded !== {32'h0, 24'h332211, 8'hB4, 2'b10}) begin
         fails++; $display("FAIL term3_coded: got %h want %h", o_tx_coded,
                           {32'h0, 24'h332211, 8'hB4, 2'b10});
      end
      vectors++;
      if (dut.state_q !== TX_T) begin
         fails++; $display("FAIL term3_state: got %0d want %0d", dut.state_q, TX_T);
      end
   endtask

   task automatic test_hold;
      apply(8'h00, 64'hDEADBEEFDEADBEEF, 1'b0);
      vectors++;
      if (o_valid !== 1'b0) begin
         fails++; $display("FAIL hold_valid: got %b want 0", o_valid);
      end
      vectors++;
      if (o_tx_coded !== {32'h0, 24'h332211, 8'hB4, 2'b10}) begin
         fails++; $display("FAIL hold_coded: got %h want %h", o_tx_coded,
                           {32'h0, 24'h332211, 8'hB4, 2'b10});
      end
      vectors++;
      if (dut.state_q !== TX_T) begin
         fails++; $display("FAIL hold_state: got %0d want %0d", dut.state_q, TX_T);
      end
   endtask

   task automatic test_back_to_back;
      apply(8'h01, 64'h00000000000000FB, 1'b1);
      apply(8'hFF, 64'h07070707070707FD, 1'b1);
      vectors++;
      if (o_tx_coded !== {56'h0, 8'h87, 2'b10}) begin
         fails++; $display("FAIL term0_coded: got %h want %h", o_tx_coded,
                           {56'h0, 8'h87, 2'b10});
      end
      apply(8'h01, 64'h00000000000000FB, 1'b1);
      apply(8'h80, 64'hFD00112233445566, 1'b1);
      vectors++;
      if (o_tx_coded !== {56'h00112233445566, 8'hFF, 2'b10}) begin
         fails++; $display("FAIL term7_coded: got %h want %h", o_tx_coded,
                           {56'h00112233445566, 8'hFF, 2'b10});
      end
      vectors++;
      if (o_frame_count !== 16'd3) begin
         fails++; $display("FAIL b2b_frame: got %h want 0003", o_frame_count);
      end
      apply(8'hFF, 64'h07070707070707FE, 1'b1);
      vectors++;
      if (o_tx_coded !== {64'h0000000000001E1E, 2'b10}) begin
         fails++; $display("FAIL ctrl_err_char: got %h want %h", o_tx_coded,
                           {64'h0000000000001E1E, 2'b10});
      end
   endtask

   task automatic test_violation;
      apply(8'h00, 64'hA5A5A5A5A5A5A5A5, 1'b1);
      vectors++;
      if (o_tx_coded !== ErrBlk) begin
         fails++; $display("FAIL viol_coded: got %h want %h", o_tx_coded, ErrBlk);
      end
      vectors++;
      if (o_err_count !== 16'd1) begin
         fails++; $display("FAIL viol_err: got %h want 0001", o_err_count);
      end
      vectors++;
      if (dut.state_q !== TX_E) begin
         fails++; $display("FAIL viol_state: got %0d want %0d", dut.state_q, TX_E);
      end
      apply(8'hFF, 64'h0707070707070707, 1'b1);
      vectors++;
      if (o_tx_coded !== IdleBlk) begin
         fails++; $display("FAIL recover_coded: got %h want %h", o_tx_coded, IdleBlk);
      end
      vectors++;
      if (dut.state_q !== TX_C) begin
         fails++; $display("FAIL recover_state: got %0d want %0d", dut.state_q, TX_C);
      end
   endtask

   task automatic test_reset_midframe;
      apply(8'h01, 64'h00000000000000FB, 1'b1);
      apply(8'h00, 64'h0102030405060708, 1'b1);
      i_tx_ctrl = 8'h00;
      i_tx_data = 64'h1111111111111111;
      i_valid   = 1'b1;
      #2;
      i_rst = 1'b1;
      #1;
      vectors++;
      if (o_valid !== 1'b0) begin
         fails++; $display("FAIL mid_rst_valid: got %b want 0", o_valid);
      end
      vectors++;
      if (o_tx_coded !== IdleBlk) begin
         fails++; $display("FAIL mid_rst_coded: got %h want %h", o_tx_coded, IdleBlk);
      end
      vectors++;
      if (o_frame_count !== 16'h0) begin
         fails++; $display("FAIL mid_rst_frame: got %h want 0000", o_frame_count);
      end
      vectors++;
      if (o_err_count !== 16'h0) begin
         fails++; $display("FAIL mid_rst_err: got %h want 0000", o_err_count);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_rst   = 1'b0;
      vectors++;
      if (dut.state_q !== TX_INIT) begin
         fails++; $display("FAIL mid_rst_state: got %0d want %0d", dut.state_q, TX_INIT);
      end
      // A data word straight out of reset is illegal from TX_INIT.
      apply(8'h00, 64'h1111111111111111, 1'b1);
      vectors++;
      if (o_tx_coded !== ErrBlk) begin
         fails++; $display("FAIL post_rst_coded: got %h want %h", o_tx_coded, ErrBlk);
      end
      vectors++;
      if (o_err_count !== 16'd1) begin
         fails++; $display("FAIL post_rst_err: got %h want 0001", o_err_count);
      end
   endtask

   task automatic test_start_lane4;
      apply(8'hFF, 64'h0707070707070707, 1'b1);
      apply(8'h1F, 64'h555555FB07070707, 1'b1);
      vectors++;
      if (o_tx_coded !== ErrBlk) begin
         fails++; $display("FAIL lane4_coded: got %h want %h", o_tx_coded, ErrBlk);
      end
      vectors++;
      if (o_err_count !== 16'd2) begin
         fails++; $display("FAIL lane4_err: got %h want 0002", o_err_count);
      end
   endtask

   task automatic test_err_saturation;
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      for (int i = 1; i <= 65536; i++) begin
         apply(8'h1F, 64'h555555FB07070707, 1'b1);
         if (i == 65534) begin
            vectors++;
            if (o_err_count !== 16'hFFFE) begin
               fails++; $display("FAIL sat_pre: got %h want fffe", o_err_count);
            end
         end
         if (i == 65535 || i == 65536) begin
            vectors++;
            if (o_err_count !== 16'hFFFF) begin
               fails++; $display("FAIL sat_hold_%0d: got %h want ffff", i, o_err_count);
            end
         end
      end
      vectors++;
      if (o_tx_coded !== ErrBlk) begin
         fails++; $display("FAIL sat_coded: got %h want %h", o_tx_coded, ErrBlk);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_start();
      test_data_term();
      test_hold();
      test_back_to_back();
      test_violation();
      test_reset_midframe();
      test_start_lane4();
      test_err_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
